// File: rtl/serial_word_feeder_pkg.sv
// Shared types for the serial word feeder.
// State encoding and counter width helper.
package serial_word_feeder_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SHIFT   = 2'd1,
      CAPTURE = 2'd2,
      OUT     = 2'd3
   } state_e;

   function automatic int cnt_w(input int w);
      return (w < 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/serial_word_feeder_shreg.sv
// Load / shift-left register presenting its MSB as the serial bit.
module serial_word_feeder_shreg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         shift,
   input  logic [W-1:0] d,
   output logic         msb
);

   logic [W-1:0] sr_q;
   logic [W-1:0] sr_d;

   always_comb begin
      sr_d = sr_q;
      if (load) begin
         sr_d = d;
      end else if (shift) begin
         sr_d = {sr_q[W-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign msb = sr_q[W-1];

endmodule

// File: rtl/serial_word_feeder.sv
// Streams a word MSB-first into a serial divisibility checker and returns its flag.
// SERIAL_WORD_FEEDER_BACK_TO_BACK_EN lets OUT accept the next word directly.
module serial_word_feeder
   import serial_word_feeder_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_word,
   output logic         chk_clear,
   output logic         new_bit,
   input  logic         div_in,
   output logic         res_valid,
   input  logic         res_ready,
   output logic         res_div,
   output logic [W-1:0] res_word
);

   localparam int CW = cnt_w(W);

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            res_div_q, res_div_d;
   logic [W-1:0]    res_word_q, res_word_d;
   logic            load, shift, msb;

   serial_word_feeder_shreg #(.W(W)) u_shreg (
      .clk   (clk),
      .rst   (rst),
      .load  (load),
      .shift (shift),
      .d     (in_word),
      .msb   (msb)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      res_div_d  = res_div_q;
      res_word_d = res_word_q;
      load       = 1'b0;
      shift      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               load       = 1'b1;
               res_word_d = in_word;
               cnt_d      = CW'(W - 1);
               state_d    = SHIFT;
            end
         end
         SHIFT: begin
            shift = 1'b1;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == '0) begin
               state_d = CAPTURE;
            end
         end
         CAPTURE: begin
            res_div_d = div_in;
            state_d   = OUT;
         end
         OUT: begin
            if (res_ready) begin
               state_d = IDLE;
`ifdef SERIAL_WORD_FEEDER_BACK_TO_BACK_EN
               // checker is already held clear here, so shifting can start at once
               if (in_valid) begin
                  load       = 1'b1;
                  res_word_d = in_word;
                  cnt_d      = CW'(W - 1);
                  state_d    = SHIFT;
               end
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         res_div_q  <= 1'b0;
         res_word_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         res_div_q  <= res_div_d;
         res_word_q <= res_word_d;
      end
   end

`ifdef SERIAL_WORD_FEEDER_BACK_TO_BACK_EN
   assign in_ready = (state_q == IDLE) || ((state_q == OUT) && res_ready);
`else
   assign in_ready = (state_q == IDLE);
`endif

   assign chk_clear = (state_q != SHIFT);
   assign new_bit   = (state_q == SHIFT) && msb;
   assign res_valid = (state_q == OUT);
   assign res_div   = res_div_q;
   assign res_word  = res_word_q;

endmodule

// File: tb/tb_serial_word_feeder.sv
// Bench for serial_word_feeder driving a behavioural mod-5 serial checker.
// Expectations come from word % 5 and the documented bit/latency timing.
module tb_serial_word_feeder;

   localparam int W = 8;
`ifdef SERIAL_WORD_FEEDER_BACK_TO_BACK_EN
   localparam int SPACING = W + 2;
`else
   localparam int SPACING = W + 3;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_word = '0;
   logic         chk_clear;
   logic         new_bit;
   logic         div_in;
   logic         res_valid;
   logic         res_ready = 1'b1;
   logic         res_div;
   logic [W-1:0] res_word;

   serial_word_feeder #(.W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_word   (in_word),
      .chk_clear (chk_clear),
      .new_bit   (new_bit),
      .div_in    (div_in),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_div   (res_div),
      .res_word  (res_word)
   );

   always #5 clk = ~clk;

   // serial divide-by-5 checker with synchronous clear
   logic [2:0] rem = 3'd0;
   always @(posedge clk) begin
      if (chk_clear) rem <= 3'd0;
      else rem <= 3'((int'(rem) * 2 + int'(new_bit)) % 5);
   end
   assign div_in = (rem == 3'd0);

   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   int cyc = 0;
   always @(posedge clk) cyc++;

   logic [W-1:0] exp_q[$];
   int           hs_q[$];
   logic         bit_q[$];
   int           done_q[$];
   int           n_hs = 0;
   int           n_drop = 0;
   bit           in_res = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         n_drop += exp_q.size();
         exp_q.delete();
         hs_q.delete();
         bit_q.delete();
         in_res = 1'b0;
      end else begin
         if (bit_q.size() > 0) begin
            check("chk_clear_shift", 32'(chk_clear), 32'd0);
            check("new_bit", 32'(new_bit), 32'(bit_q.pop_front()));
         end else begin
            check("chk_clear_idle", 32'(chk_clear), 32'd1);
            check("new_bit_idle", 32'(new_bit), 32'd0);
         end
`ifdef SERIAL_WORD_FEEDER_BACK_TO_BACK_EN
         check("in_ready", 32'(in_ready),
               32'(exp_q.size() == 0 || (res_valid && res_ready)));
`else
         check("in_ready", 32'(in_ready), 32'(exp_q.size() == 0));
`endif
         if (res_valid) begin
            if (exp_q.size() == 0) begin
               check("res_valid_stale", 32'(res_valid), 32'd0);
            end else begin
               if (!in_res) begin
                  check("latency", 32'(cyc - hs_q[0] + 1), 32'(W + 2));
                  in_res = 1'b1;
               end
               check("res_word", 32'(res_word), 32'(exp_q[0]));
               check("res_div", 32'(res_div), 32'(exp_q[0] % 8'd5 == 8'd0));
               if (res_ready) begin
                  void'(exp_q.pop_front());
                  void'(hs_q.pop_front());
                  done_q.push_back(cyc);
                  in_res = 1'b0;
               end
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(in_word);
            hs_q.push_back(cyc + 1);
            n_hs++;
            for (int i = W - 1; i >= 0; i--) bit_q.push_back(in_word[i]);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [W-1:0] w, input bit keep);
      in_valid = 1'b1;
      in_word  = w;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            #1;
            if (!keep) in_valid = 1'b0;
            return;
         end
      end
      check("hs_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !res_valid) begin
            tick(1);
            return;
         end
      end
      check("idle_timeout", 32'(exp_q.size()), 32'd0);
   endtask

   bit sdone;
   int d0;

   initial begin
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_chk_clear", 32'(chk_clear), 32'd1);
      check("rst_new_bit", 32'(new_bit), 32'd0);
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_res_div", 32'(res_div), 32'd0);
      check("rst_res_word", 32'(res_word), 32'd0);
      tick(2);
      rst = 1'b0;
      tick(1);

      send(8'hA5, 1'b0);
      wait_idle();
      send(8'h0F, 1'b0); wait_idle();
      send(8'h07, 1'b0); wait_idle();
      send(8'hFF, 1'b0); wait_idle();
      send(8'h00, 1'b0); wait_idle();

      res_ready = 1'b0;
      d0 = done_q.size();
      send(8'h19, 1'b0);
      for (int i = 0; i < 50 && !res_valid; i++) @(negedge clk);
      check("bp_valid", 32'(res_valid), 32'd1);
      repeat (5) begin
         @(negedge clk);
         check("bp_valid_hold", 32'(res_valid), 32'd1);
         check("bp_in_ready", 32'(in_ready), 32'd0);
      end
      tick(1);
      res_ready = 1'b1;
      tick(3);
      check("bp_single", 32'(done_q.size() - d0), 32'd1);

      d0 = done_q.size();
      send(8'h32, 1'b0);
      tick(3);
      #1;
      rst = 1'b1;
      #1;
      check("rst_mid_clear", 32'(chk_clear), 32'd1);
      check("rst_mid_valid", 32'(res_valid), 32'd0);
      check("rst_mid_bit", 32'(new_bit), 32'd0);
      tick(2);
      rst = 1'b0;
      tick(1);
      send(8'h0A, 1'b0);
      wait_idle();
      check("rst_no_stale", 32'(done_q.size() - d0), 32'd1);

      d0 = done_q.size();
      send(8'h05, 1'b1);
      send(8'h06, 1'b1);
      send(8'h14, 1'b0);
      wait_idle();
      check("b2b_count", 32'(done_q.size() - d0), 32'd3);
      if (done_q.size() - d0 == 3) begin
         check("b2b_gap1", 32'(done_q[d0+1] - done_q[d0]), 32'(SPACING));
         check("b2b_gap2", 32'(done_q[d0+2] - done_q[d0+1]), 32'(SPACING));
      end

      sdone = 1'b0;
      fork
         begin
            for (int k = 0; k < 40; k++) begin
               if ($urandom_range(0, 2) == 0) tick($urandom_range(1, 3));
               send(W'($urandom), 1'b0);
            end
            sdone = 1'b1;
         end
         begin
            while (!sdone) begin
               @(posedge clk);
               #1;
               res_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      res_ready = 1'b1;
      wait_idle();
      check("total_done", 32'(done_q.size()), 32'(n_hs - n_drop));

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
